// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial mod-Q add/sub datapath:
// default ring parameters, mode encoding and the control FSM states.
package poly_pkg;

   localparam int unsigned Q_DEF = 1049089;
   localparam int unsigned W_DEF = 21;
   localparam int unsigned N_DEF = 256;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/poly_modq_lane.sv
// Single-coefficient modular adder/subtractor over Z_Q (combinational).
// Optional range flag built only when POLY_MODQ_RANGE_CHK_EN is defined.
module poly_modq_lane
   import poly_pkg::*;
#(
   parameter int unsigned Q = Q_DEF,
   parameter int unsigned W = W_DEF
) (
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] r,
   output logic         range_err
);

   localparam logic [W:0] Q_EXT = Q[W:0];

   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] sum;
   logic [W:0] res;
   logic       unused_msb;

   // One conditional correction by Q brings an in-range sum/difference back into [0, Q);
   // out-of-range operands simply get the truncated result of the same formula.
   always_comb begin
      a_ext = {1'b0, a};
      b_ext = {1'b0, b};
      sum   = a_ext + b_ext;
      res   = '0;
      if (mode == MODE_ADD) begin
         res = (sum >= Q_EXT) ? (sum - Q_EXT) : sum;
      end else begin
         res = (a_ext >= b_ext) ? (a_ext - b_ext) : (a_ext + Q_EXT - b_ext);
      end
   end

   assign r          = res[W-1:0];
   assign unused_msb = res[W];

`ifdef POLY_MODQ_RANGE_CHK_EN
   assign range_err = (a_ext >= Q_EXT) || (b_ext >= Q_EXT);
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: rtl/poly_modq_addsub.sv
// Streaming coefficient-wise mod-Q adder/subtractor for N-coefficient polynomials.
// LANES coefficient pairs per accepted beat; packed result held until next start.
// Optional sticky range checking enabled with the POLY_MODQ_RANGE_CHK_EN macro.
module poly_modq_addsub
   import poly_pkg::*;
#(
   parameter int unsigned Q     = Q_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned N     = N_DEF,
   parameter int unsigned LANES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] a_in,
   input  logic [LANES*W-1:0] b_in,
   output logic               busy,
   output logic               done,
   output logic [N*W-1:0]     result,
   output logic               err
);

   localparam int unsigned BEATS = N / LANES;
   localparam int unsigned CW    = $clog2(BEATS) + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic            mode_reg;
   logic [N*W-1:0]  result_reg;
   logic            in_ready_reg;
   logic            busy_reg;
   logic            done_reg;

   logic [W-1:0]     lane_r [LANES];
   logic [LANES-1:0] lane_err;
   logic             accept;
   logic             start_fire;

   // in_ready_reg is only ever high in RUN, so it doubles as the state qualifier.
   assign accept     = in_valid && in_ready_reg;
   assign start_fire = (state_reg == IDLE) && start;

   generate
      for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_lane
         poly_modq_lane #(.Q(Q), .W(W)) u_lane (
            .mode      (mode_reg),
            .a         (a_in[gi*W +: W]),
            .b         (b_in[gi*W +: W]),
            .r         (lane_r[gi]),
            .range_err (lane_err[gi])
         );
      end
   endgenerate

   // Control FSM plus result assembly; status outputs are registered alongside state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         mode_reg     <= MODE_ADD;
         result_reg   <= '0;
         in_ready_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg    <= RUN;
                  mode_reg     <= mode;
                  cnt_reg      <= '0;
                  result_reg   <= '0;
                  in_ready_reg <= 1'b1;
                  busy_reg     <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  for (int k = 0; k < int'(LANES); k++) begin
                     result_reg[(int'(cnt_reg) * int'(LANES) + k) * int'(W) +: W] <= lane_r[k];
                  end
                  // The counter stops on the final beat rather than wrapping.
                  if (cnt_reg == LAST_BEAT) begin
                     state_reg    <= FIN;
                     in_ready_reg <= 1'b0;
                     done_reg     <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            FIN: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg    <= IDLE;
               in_ready_reg <= 1'b0;
               busy_reg     <= 1'b0;
               done_reg     <= 1'b0;
            end
         endcase
      end
   end

`ifdef POLY_MODQ_RANGE_CHK_EN
   logic err_reg;

   // Sticky flag: any accepted out-of-range lane sets it; only a new run or reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if (start_fire) begin
         err_reg <= 1'b0;
      end else if (accept && (|lane_err)) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   logic unused_err;
   assign unused_err = (^lane_err) ^ start_fire;
   assign err        = 1'b0;
`endif

   assign in_ready = in_ready_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign result   = result_reg;

endmodule

// File: tb/tb_poly_modq_addsub.sv
// Self-checking bench for poly_modq_addsub (LANES=4): directed runs with a result
// scoreboard, random in_valid gaps, mid-run reset and optional range-flag checks
// (range checks follow POLY_MODQ_RANGE_CHK_EN when defined).
module tb_poly_modq_addsub;

   localparam int unsigned Q     = 1049089;
   localparam int unsigned W     = 21;
   localparam int unsigned N     = 256;
   localparam int unsigned L     = 4;
   localparam int unsigned BEATS = N / L;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [L*W-1:0]   a_in = '0;
   logic [L*W-1:0]   b_in = '0;
   logic             busy;
   logic             done;
   logic [N*W-1:0]   result;
   logic             err;

   logic [W-1:0]     a_arr [N];
   logic [W-1:0]     b_arr [N];
   logic [N*W-1:0]   exp_q [$];
   logic [N*W-1:0]   last_exp = '0;
   int               errors = 0;
   int               checks = 0;

   poly_modq_addsub #(.Q(Q), .W(W), .N(N), .LANES(L)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference arithmetic in plain integers, truncated to W bits at the end.
   function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
      longint s;
      if (!m) begin
         s = longint'(a) + longint'(b);
         if (s >= longint'(Q)) s = s - longint'(Q);
      end else begin
         if (a >= b) s = longint'(a) - longint'(b);
         else        s = longint'(a) + longint'(Q) - longint'(b);
      end
      return s[W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         int idx;
         idx = 0;
         for (int i = N - 1; i >= 0; i--) begin
            if (obs[i*W +: W] !== exp[i*W +: W]) idx = i;
         end
         errors++;
         $error("FAIL %s coef=%0d observed=%0d expected=%0d", tag, idx, obs[idx*W +: W], exp[idx*W +: W]);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         a_arr[i] = W'($urandom_range(Q - 1));
         b_arr[i] = W'($urandom_range(Q - 1));
      end
   endtask

   // Full run from IDLE; caller is positioned 1 time unit after a rising edge.
   task automatic run_poly(input string name, input logic m, input int gap_pct,
                           input bit toggle_mode, input bit poke_start);
      logic [N*W-1:0] exp;
      logic           exp_err;
      int             accepted;
      int             lat;
      bit             early_done;
      exp     = '0;
      exp_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp[i*W +: W] = model(m, a_arr[i], b_arr[i]);
`ifdef POLY_MODQ_RANGE_CHK_EN
         if (a_arr[i] >= W'(Q) || b_arr[i] >= W'(Q)) exp_err = 1'b1;
`endif
      end
      exp_q.push_back(exp);

      start = 1'b1;
      mode  = m;
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_start_in_ready"}, in_ready, 1);
      chk({name, "_start_busy"}, busy, 1);
      chk({name, "_start_err"}, err, 0);

      accepted   = 0;
      early_done = 1'b0;
      for (int j = 0; j < int'(BEATS); j++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            a_in     = {L{W'($urandom)}};
            b_in     = {L{W'($urandom)}};
            if (toggle_mode) mode = ~mode;
            @(posedge clk); #1;
            if (done) early_done = 1'b1;
         end
         in_valid = 1'b1;
         for (int k = 0; k < int'(L); k++) begin
            a_in[k*W +: W] = a_arr[j*int'(L) + k];
            b_in[k*W +: W] = b_arr[j*int'(L) + k];
         end
         if (toggle_mode) mode = ~mode;
         if (poke_start && j == 10) start = 1'b1;
         if (in_ready) accepted++;
         @(posedge clk); #1;
         start = 1'b0;
         if (j < int'(BEATS) - 1 && done) early_done = 1'b1;
      end
      in_valid = 1'b0;

      lat = 0;
      while (!done && lat < 4) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_done_latency"}, lat, 0);
      chk({name, "_beats_accepted"}, accepted, BEATS);
      chk({name, "_no_early_done"}, early_done, 0);
      chk({name, "_fin_busy"}, busy, 1);
      chk({name, "_fin_in_ready"}, in_ready, 0);
      chk({name, "_err"}, err, exp_err);
      exp = exp_q.pop_front();
      chk_res({name, "_result"}, result, exp);
      last_exp = exp;
      $display("run %s mode=%0d gap=%0d%% accepted=%0d", name, m, gap_pct, accepted);

      @(posedge clk); #1;
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_err", err, 0);
      chk_res("rst_result", result, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Add, single non-zero pair at coefficient 0
      for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
      a_arr[0] = 21'd1000;
      b_arr[0] = 21'd2000;
      run_poly("add_basic", 1'b0, 0, 1'b0, 1'b0);
      chk("add_basic_coef0", result[0 +: W], 3000);

      // Result holds in IDLE while in_valid is driven
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         a_in = {L{W'($urandom)}};
         b_in = {L{W'($urandom)}};
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk_res("idle_hold_result", result, last_exp);
      chk("idle_in_ready", in_ready, 0);

      // Add wrap: Q-1 + Q-1, plus a pair summing to exactly Q
      for (int i = 0; i < N; i++) begin a_arr[i] = W'(Q - 1); b_arr[i] = W'(Q - 1); end
      a_arr[5] = 21'd524544;
      b_arr[5] = 21'd524545;
      run_poly("add_wrap", 1'b0, 0, 1'b0, 1'b0);
      chk("add_wrap_coef0", result[0 +: W], 1049087);
      chk("add_wrap_coef5", result[5*W +: W], 0);

      // Sub with mode toggling and a start pulse during RUN (both must be ignored)
      fill_random();
      a_arr[0] = 21'd7; b_arr[0] = 21'd5;
      a_arr[1] = 21'd5; b_arr[1] = 21'd7;
      a_arr[2] = 21'd0; b_arr[2] = 21'd0;
      run_poly("sub_toggle", 1'b1, 0, 1'b1, 1'b1);
      chk("sub_coef0", result[0 +: W], 2);
      chk("sub_coef1", result[W +: W], 1049087);
      chk("sub_coef2", result[2*W +: W], 0);

      // Random data with ~30% idle beats, both modes
      fill_random();
      run_poly("add_gaps", 1'b0, 30, 1'b0, 1'b0);
      fill_random();
      run_poly("sub_gaps", 1'b1, 30, 1'b1, 1'b0);

      // Reset in the middle of a run
      fill_random();
      start = 1'b1;
      mode  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         in_valid = 1'b1;
         for (int k = 0; k < int'(L); k++) begin
            a_in[k*W +: W] = a_arr[j*int'(L) + k];
            b_in[k*W +: W] = b_arr[j*int'(L) + k];
         end
         @(posedge clk); #1;
      end
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done, 0);
      chk_res("midrst_result", result, '0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 0);
      fill_random();
      run_poly("after_rst", 1'b1, 20, 1'b0, 1'b0);

`ifdef POLY_MODQ_RANGE_CHK_EN
      // Out-of-range operand on beat 3 (coefficient 12)
      fill_random();
      a_arr[3*L] = W'(Q);
      run_poly("range", 1'b0, 0, 1'b0, 1'b0);
      fill_random();
      run_poly("range_clear", 1'b0, 0, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
